// File: rtl/xpb_pkg.sv
// Shared defaults, result-width helper and FSM state type for the xpb accumulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xpb_pkg;

  localparam int DIGIT_BITS_DEF = 5;
  localparam int NUM_DIGITS_DEF = 8;
  localparam int WORD_BITS_DEF  = 1024;

  // One word plus every table term can never exceed this many bits.
  function automatic int acc_bits(input int word_bits, input int num_digits);
    return word_bits + $clog2(num_digits + 1);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HOLD    = 2'd3
  } xpb_acc_state_t;

endpackage

// File: rtl/xpb_serial_accum_csa_3to2.sv
// Bitwise 3:2 compressor: a+b+c == sum+carry (carry already shifted left by one).
// Latency: combinational.
// Backpressure: none.
module csa_3to2 #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  // Majority per bit; the top carry-out is dropped because callers size W so it is always zero.
  always_comb begin
    maj   = (a & b) | (a & c) | (b & c);
    sum   = a ^ b ^ c;
    carry = maj << 1;
  end

endmodule

// File: rtl/xpb_serial_accum.sv
// Serial carry-save reduction of in_base plus one xpb table word per digit; XPB_SKIP_ZERO_EN skips zero digits.
// Latency: out_valid NUM_DIGITS+1 cycles after acceptance (non-zero digit count + 1 with XPB_SKIP_ZERO_EN).
// Backpressure: in_ready only in IDLE; result held stable in HOLD until out_ready, no queuing of in_valid.
module xpb_serial_accum
  import xpb_pkg::*;
#(
  parameter int DIGIT_BITS = DIGIT_BITS_DEF,
  parameter int NUM_DIGITS = NUM_DIGITS_DEF,
  parameter int WORD_BITS  = WORD_BITS_DEF,
  parameter int ACC_BITS   = acc_bits(WORD_BITS, NUM_DIGITS)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] in_digits,
  input  logic [WORD_BITS-1:0]             in_base,
  output logic [$clog2(NUM_DIGITS)-1:0]    lut_idx,
  output logic [DIGIT_BITS-1:0]            lut_sel,
  input  logic [WORD_BITS-1:0]             lut_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_BITS-1:0]              out_sum
);

  localparam int IDX_BITS = $clog2(NUM_DIGITS);

  xpb_acc_state_t                   state_q, state_d;
  logic [IDX_BITS-1:0]              cnt_q, cnt_d;
  logic [NUM_DIGITS*DIGIT_BITS-1:0] digits_q;
  logic [ACC_BITS-1:0]              acc_s, acc_c;
  logic [ACC_BITS-1:0]              csa_s, csa_c;
  logic [ACC_BITS-1:0]              sum_q;
  logic [DIGIT_BITS-1:0]            cur_digit;
  logic                             load, accum, resolve;

  assign cur_digit = digits_q[int'(cnt_q)*DIGIT_BITS +: DIGIT_BITS];

  csa_3to2 #(.W(ACC_BITS)) u_csa (
    .a     (acc_s),
    .b     (acc_c),
    .c     (ACC_BITS'(lut_data)),
    .sum   (csa_s),
    .carry (csa_c)
  );

`ifdef XPB_SKIP_ZERO_EN
  logic                first_found, next_found;
  logic [IDX_BITS-1:0] first_idx, next_idx;

  // Lowest non-zero digit of the offered word, and lowest non-zero registered digit above cnt.
  always_comb begin
    first_found = 1'b0;
    first_idx   = '0;
    next_found  = 1'b0;
    next_idx    = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (|in_digits[i*DIGIT_BITS +: DIGIT_BITS]) begin
        first_found = 1'b1;
        first_idx   = IDX_BITS'(i);
      end
      if ((|digits_q[i*DIGIT_BITS +: DIGIT_BITS]) && (i > int'(cnt_q))) begin
        next_found = 1'b1;
        next_idx   = IDX_BITS'(i);
      end
    end
  end
`endif

  // Next-state, digit walk and table drive; lut outputs are zero outside ACCUM so tables return 0.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    accum    = 1'b0;
    resolve  = 1'b0;
    in_ready = 1'b0;
    lut_idx  = '0;
    lut_sel  = '0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
`ifdef XPB_SKIP_ZERO_EN
          if (first_found) begin
            state_d = ST_ACCUM;
            cnt_d   = first_idx;
          end else begin
            state_d = ST_RESOLVE;
          end
`else
          state_d = ST_ACCUM;
          cnt_d   = '0;
`endif
        end
      end
      ST_ACCUM: begin
        lut_idx = cnt_q;
        lut_sel = cur_digit;
        accum   = 1'b1;
`ifdef XPB_SKIP_ZERO_EN
        if (next_found) begin
          cnt_d = next_idx;
        end else begin
          state_d = ST_RESOLVE;
        end
`else
        if (cnt_q == IDX_BITS'(NUM_DIGITS - 1)) begin
          state_d = ST_RESOLVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESOLVE: begin
        resolve = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and digit-position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Carry-save accumulation and the single wide resolve add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
      acc_s    <= '0;
      acc_c    <= '0;
      sum_q    <= '0;
    end else begin
      if (load) begin
        digits_q <= in_digits;
        acc_s    <= ACC_BITS'(in_base);
        acc_c    <= '0;
      end else if (accum) begin
        acc_s <= csa_s;
        acc_c <= csa_c;
      end
      if (resolve) begin
        sum_q <= acc_s + acc_c;
      end
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_xpb_serial_accum.sv
// Bench for xpb_serial_accum: vector table, reset abort sequence and random transactions vs a reference sum.
// Latency: expected per transaction from the visited-digit list.
// Backpressure: exercises HOLD stalls and ignored in_valid pulses.
module tb_xpb_serial_accum;

  localparam int ND = 8;
  localparam int DB = 5;
  localparam int WB = 1024;
  localparam int AB = 1028;
`ifdef XPB_SKIP_ZERO_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ND*DB-1:0] in_digits = '0;
  logic [WB-1:0]    in_base = '0;
  logic [2:0]       lut_idx;
  logic [DB-1:0]    lut_sel;
  logic [WB-1:0]    lut_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AB-1:0]    out_sum;

  int               total = 0;
  int               bad = 0;
  int               lut_mode = 0;
  logic [WB-1:0]    tab [ND][32];

  always #5 clk = ~clk;

  xpb_serial_accum dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_digits (in_digits),
    .in_base   (in_base),
    .lut_idx   (lut_idx),
    .lut_sel   (lut_sel),
    .lut_data  (lut_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum)
  );

  // Table bank model, selected per test.
  always_comb begin
    lut_data = '0;
    case (lut_mode)
      1:       lut_data = WB'(int'(lut_sel) * (int'(lut_idx) + 1));
      2:       lut_data = '1;
      3:       lut_data = tab[lut_idx][lut_sel];
      default: lut_data = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [AB-1:0] act, input logic [AB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual hi=%h lo=%h required hi=%h lo=%h",
               nm, act[AB-1:AB-64], act[63:0], exp[AB-1:AB-64], exp[63:0]);
    end
  endtask

  function automatic logic [DB-1:0] dig_of(input logic [ND*DB-1:0] d, input int i);
    return d[i*DB +: DB];
  endfunction

  task automatic run_txn(input logic [ND*DB-1:0] dig, input logic [WB-1:0] base, input int mode,
                         input int hold, input logic [AB-1:0] exp_sum, input string nm);
    int            vis[$];
    int            lat;
    int            lat_seen;
    int            waitc;
    bit            seq_ok;
    bit            hold_ok;
    logic [AB-1:0] held;
    for (int i = 0; i < ND; i++) begin
      if (!SKIP || dig_of(dig, i) != '0) vis.push_back(i);
    end
    lat = vis.size() + 1;
    lut_mode = mode;
    @(negedge clk);
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    chk({nm, "_ready"}, AB'(in_ready), AB'(1));
    in_valid  = 1'b1;
    in_digits = dig;
    in_base   = base;
    @(negedge clk);
    in_valid  = 1'b0;
    in_digits = {$urandom(), 8'($urandom())};
    in_base   = {32{$urandom()}};
    seq_ok    = 1'b1;
    lat_seen  = -1;
    for (int w = 0; w <= lat + 4; w++) begin
      if (w < vis.size()) begin
        if (int'(lut_idx) != vis[w] || lut_sel != dig_of(dig, vis[w])) seq_ok = 1'b0;
      end else if (lut_idx != '0 || lut_sel != '0) begin
        seq_ok = 1'b0;
      end
      if (out_valid) begin
        lat_seen = w;
        break;
      end
      if (in_ready) seq_ok = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_lutseq"}, AB'(seq_ok), AB'(1));
    chk({nm, "_latency"}, AB'(lat_seen), AB'(lat));
    chk({nm, "_sum"}, out_sum, exp_sum);
    held    = out_sum;
    hold_ok = 1'b1;
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 1);
      @(negedge clk);
      if (!out_valid || in_ready || out_sum !== held) hold_ok = 1'b0;
    end
    in_valid = 1'b0;
    if (hold > 0) chk({nm, "_hold"}, AB'(hold_ok), AB'(1));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_done"}, AB'({out_valid, in_ready}), AB'(2'b01));
  endtask

  typedef struct {
    logic [ND*DB-1:0] digits;
    logic [WB-1:0]    base;
    int               mode;
    int               hold;
    logic [AB-1:0]    exp_sum;
    string            name;
  } vec_t;

  initial begin
    vec_t             vecs[5];
    logic [WB-1:0]    ones;
    logic [AB-1:0]    ones_x;
    logic [ND*DB-1:0] d;
    logic [WB-1:0]    b;
    logic [AB-1:0]    ref_sum;

    ones   = '1;
    ones_x = AB'(ones);
    vecs[0] = '{'0, '0, 0, 0, AB'(0), "zero"};
    vecs[1] = '{{ND{5'd1}}, WB'(5), 1, 0, AB'(41), "ones"};
    vecs[2] = '{{ND{5'd31}}, ones, 2, 0, (ones_x << 3) + ones_x, "maxw"};
    vecs[3] = '{{ND{5'd1}}, WB'(5), 1, 5, AB'(41), "stall"};
    vecs[4] = '{(40'd3 << 10) | (40'd1 << 30), '0, 1, 1, AB'(16), "sparse"};

    for (int i = 0; i < ND; i++) begin
      tab[i][0] = '0;
      for (int s = 1; s < 32; s++) begin
        for (int j = 0; j < WB / 32; j++) tab[i][s][j*32 +: 32] = $urandom();
      end
    end

    // Reset state.
    #2;
    chk("rst_outs", AB'({in_ready, out_valid, lut_idx, lut_sel}), AB'({1'b1, 1'b0, 3'd0, 5'd0}));
    chk("rst_sum", out_sum, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].digits, vecs[v].base, vecs[v].mode, vecs[v].hold, vecs[v].exp_sum, vecs[v].name);
    end

    // Reset during the fourth ACCUM cycle aborts the transaction.
    lut_mode  = 1;
    in_valid  = 1'b1;
    in_digits = {ND{5'd1}};
    in_base   = WB'(5);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pre_idx", AB'({lut_idx, lut_sel}), AB'({3'd3, 5'd1}));
    rst_n = 1'b0;
    #1;
    chk("abort_outs", AB'({in_ready, out_valid, lut_idx, lut_sel}), AB'({1'b1, 1'b0, 3'd0, 5'd0}));
    chk("abort_sum", out_sum, '0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn({ND{5'd1}}, WB'(5), 1, 0, AB'(41), "rerun");

    // Random transactions against the table model.
    for (int t = 0; t < 20; t++) begin
      d = '0;
      for (int i = 0; i < ND; i++) begin
        if ($urandom_range(0, 2) != 0) d[i*DB +: DB] = DB'($urandom_range(1, 31));
      end
      for (int j = 0; j < WB / 32; j++) b[j*32 +: 32] = $urandom();
      ref_sum = AB'(b);
      for (int i = 0; i < ND; i++) ref_sum = ref_sum + AB'(tab[i][dig_of(d, i)]);
      run_txn(d, b, 3, int'($urandom_range(0, 3)), ref_sum, $sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
